raster_scan_source: RTL and testbench

- Head-of-pipeline pixel stream generator; produces the raster (x, y, r, g, b) stream consumed by rect_renderer and the other pass-through render stages.
- Walks a programmable video timing (active plus front porch, sync and back porch, both axes). Emits a background colour inside the active area and black in blanking.
- Also emits hsync, vsync, active and frame/line markers for the downstream display-timing and sink logic.

---
 rtl/render_pkg.sv | 21 ++
 rtl/scan_counter.sv | 23 ++
 rtl/raster_scan_source.sv | 105 ++++++++++
 tb/tb_raster_scan_source.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/render_pkg.sv
// render_pkg: shared raster widths, default 640x480 timing and helpers
package render_pkg;

    localparam int X_W     = 11;
    localparam int Y_W     = 12;
    localparam int COLOR_W = 8;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    function automatic int total_len(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/scan_counter.sv
// scan_counter: modulo-MOD up counter with a wrap-carry flag
module scan_counter #(
    parameter int MOD = 8,
    parameter int W   = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         carry
);

    assign carry = count == W'(MOD - 1);

    // count up on en, wrapping to zero after MOD-1
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (en)
            count <= carry ? '0 : count + 1'b1;
    end

endmodule

// File: rtl/raster_scan_source.sv
// raster_scan_source: programmable-timing raster pixel stream generator
module raster_scan_source
    import render_pkg::*;
#(
    parameter int               H_ACTIVE = DEF_H_ACTIVE,
    parameter int               H_FP     = DEF_H_FP,
    parameter int               H_SYNC   = DEF_H_SYNC,
    parameter int               H_BP     = DEF_H_BP,
    parameter int               V_ACTIVE = DEF_V_ACTIVE,
    parameter int               V_FP     = DEF_V_FP,
    parameter int               V_SYNC   = DEF_V_SYNC,
    parameter int               V_BP     = DEF_V_BP,
    parameter bit               SYNC_POL = 1'b0,
    parameter logic [COLOR_W-1:0] BG_R   = 8'h00,
    parameter logic [COLOR_W-1:0] BG_G   = 8'h00,
    parameter logic [COLOR_W-1:0] BG_B   = 8'h00
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    output logic signed [X_W-1:0]     x,
    output logic signed [Y_W-1:0]     y,
    output logic [COLOR_W-1:0]        r,
    output logic [COLOR_W-1:0]        g,
    output logic [COLOR_W-1:0]        b,
    output logic                      hsync,
    output logic                      vsync,
    output logic                      active,
    output logic                      line_start,
    output logic                      frame_start
);

    localparam int H_TOTAL = total_len(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = total_len(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int H_W = 10;
    localparam int V_W = 11;

    localparam logic [H_W-1:0] H_A  = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] H_S0 = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] H_S1 = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0] V_A  = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] V_S0 = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] V_S1 = V_W'(V_ACTIVE + V_FP + V_SYNC);

    if (H_TOTAL > 1023 || V_TOTAL > 2047 ||
        H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
        $error("raster_scan_source: invalid timing parameters");
    end

    logic [H_W-1:0] h;
    logic [V_W-1:0] v;
    logic           h_carry;
    logic           v_carry;
    logic           vis;

    scan_counter #(.MOD(H_TOTAL), .W(H_W)) u_h (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .count (h),
        .carry (h_carry)
    );

    scan_counter #(.MOD(V_TOTAL), .W(V_W)) u_v (
        .clk   (clk),
        .rst   (rst),
        .en    (en && h_carry),
        .count (v),
        .carry (v_carry)
    );

    assign vis = (h < H_A) && (v < V_A);

    // present the current (h,v) on en; markers are single-cycle pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            x           <= '0;
            y           <= '0;
            r           <= '0;
            g           <= '0;
            b           <= '0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            active      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (en) begin
            x           <= X_W'(h);
            y           <= Y_W'(v);
            r           <= vis ? BG_R : '0;
            g           <= vis ? BG_G : '0;
            b           <= vis ? BG_B : '0;
            hsync       <= (h >= H_S0 && h < H_S1) ? SYNC_POL : ~SYNC_POL;
            vsync       <= (v >= V_S0 && v < V_S1) ? SYNC_POL : ~SYNC_POL;
            active      <= vis;
            line_start  <= h == '0;
            frame_start <= h == '0 && v == '0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_raster_scan_source.sv
// tb_raster_scan_source: scoreboard bench for the raster pixel source
module tb_raster_scan_source;

    typedef struct packed {
        logic [10:0] x;
        logic [11:0] y;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic        hs;
        logic        vs;
        logic        act;
        logic        ls;
        logic        fs;
    } pix_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic signed [10:0] x;
    logic signed [11:0] y;
    logic [7:0] r, g, b;
    logic hsync, vsync, active, line_start, frame_start;

    logic d_rst = 1'b1;
    logic d_en  = 1'b0;
    logic signed [10:0] d_x;
    logic signed [11:0] d_y;
    logic [7:0] d_r, d_g, d_b;
    logic d_hsync, d_vsync, d_active, d_line_start, d_frame_start;

    int checks = 0;
    int fails  = 0;

    pix_t exp_q[$];
    pix_t last_exp;
    int   mh = 0;
    int   mv = 0;

    always #5 clk = ~clk;

    raster_scan_source #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b0), .BG_R(8'h12), .BG_G(8'h34), .BG_B(8'h56)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .x(x), .y(y), .r(r), .g(g), .b(b),
        .hsync(hsync), .vsync(vsync), .active(active),
        .line_start(line_start), .frame_start(frame_start)
    );

    raster_scan_source dut_def (
        .clk(clk), .rst(d_rst), .en(d_en),
        .x(d_x), .y(d_y), .r(d_r), .g(d_g), .b(d_b),
        .hsync(d_hsync), .vsync(d_vsync), .active(d_active),
        .line_start(d_line_start), .frame_start(d_frame_start)
    );

    // hand timing for the small case: H 4/1/2/1 (total 8), V 3/1/1/1 (total 6)
    function automatic pix_t present(input int hh, input int vv);
        pix_t p;
        p.x   = 11'(hh);
        p.y   = 12'(vv);
        p.act = (hh < 4) && (vv < 3);
        p.r   = p.act ? 8'h12 : 8'h00;
        p.g   = p.act ? 8'h34 : 8'h00;
        p.b   = p.act ? 8'h56 : 8'h00;
        p.hs  = !(hh == 5 || hh == 6);
        p.vs  = !(vv == 4);
        p.ls  = hh == 0;
        p.fs  = hh == 0 && vv == 0;
        return p;
    endfunction

    task automatic step(input logic rst_v, input logic en_v);
        pix_t e;
        @(negedge clk);
        rst = rst_v;
        en  = en_v;
        if (rst_v) begin
            e = '{x: 0, y: 0, r: 0, g: 0, b: 0, hs: 1, vs: 1, act: 0, ls: 0, fs: 0};
            mh = 0;
            mv = 0;
        end else if (en_v) begin
            e = present(mh, mv);
            if (mh == 7) begin
                mh = 0;
                mv = (mv == 5) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
        end else begin
            e = last_exp;
            e.ls = 1'b0;
            e.fs = 1'b0;
        end
        last_exp = e;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end
    endtask

    // monitor: every clock edge presents one pixel; compare with the oldest expectation
    always @(posedge clk) begin
        pix_t e;
        pix_t got;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            got = {x, y, r, g, b, hsync, vsync, active, line_start, frame_start};
            checks++;
            if (got !== e) begin
                fails++;
                $display("FAIL pixel @%0t: got x=%0d y=%0d rgb=%h%h%h hs=%b vs=%b act=%b ls=%b fs=%b required x=%0d y=%0d rgb=%h%h%h hs=%b vs=%b act=%b ls=%b fs=%b",
                         $time, got.x, got.y, got.r, got.g, got.b, got.hs, got.vs, got.act, got.ls, got.fs,
                         e.x, e.y, e.r, e.g, e.b, e.hs, e.vs, e.act, e.ls, e.fs);
            end
        end
    end

    initial begin
        int n_ls, n_fs, n_act, n_hlow;
        repeat (3) step(1'b1, 1'b1);
        repeat (49) step(1'b0, 1'b1);
        while (!(mh == 2 && mv == 1)) step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        while (!(mh == 0 && mv == 2)) step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        while (!(mh == 7 && mv == 5)) step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        while (!(mh == 6 && mv == 4)) step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        for (int i = 0; i < 80; i++) step(1'b0, 1'($urandom_range(0, 1)));
        step(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        n_ls = 0; n_fs = 0; n_act = 0; n_hlow = 0;
        @(negedge clk);
        d_rst = 1'b1;
        d_en  = 1'b1;
        @(negedge clk);
        d_rst = 1'b0;
        for (int i = 0; i < 3 * 800; i++) begin
            @(posedge clk);
            #1;
            n_ls   += int'(d_line_start);
            n_fs   += int'(d_frame_start);
            n_act  += int'(d_active);
            n_hlow += int'(!d_hsync);
        end
        d_en = 1'b0;
        check("def_line_starts", n_ls, 3);
        check("def_frame_starts", n_fs, 1);
        check("def_active", n_act, 3 * 640);
        check("def_hsync_low", n_hlow, 3 * 96);
        check("def_last_x", int'(d_x), 799);
        check("def_last_y", int'(d_y), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

endmodule
